if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the RV32I pipeline, directly upstream of the immediate/instruction decoder.
- Keeps the PC and issues one-outstanding requests to instruction memory.
- Buffers a response that arrives while decode is stalled.
- Drives the IF/ID pipeline register (`instruction_r`, `pc_r`, `valid_r`) that the decoder consumes. Handles stall and branch/jump redirect (flush).

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INSTR, 32'h00000013, bubble instruction (`addi x0,x0,0`) placed in `instruction_r` on reset/flush

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall_i  input  1  decode/hazard stall; hold IF/ID register
redirect_i  input  1  taken branch/jump from execute; flush and refetch
redirect_pc_i  input  32  redirect target
imem_req_o  output  1  fetch request valid (combinational from state)
imem_addr_o  output  32  fetch address, word aligned
imem_rsp_valid_i  input  1  response valid, earliest 1 cycle after request
imem_rsp_data_i  input  32  fetched instruction word
instruction_r  output  32  IF/ID instruction to decoder
pc_r  output  32  IF/ID PC of `instruction_r`
valid_r  output  1  IF/ID entry valid

Behaviour:
- **Reset** (`rst=1` at edge), regardless of state:
  - pc_q=RESET_PC, state=FETCH, drop_q=0, hold buffer invalid.
  - instruction_r=NOP_INSTR, pc_r=0, valid_r=0.
- **Address alignment:** `imem_addr_o` = pc_q with bits [1:0] forced to 0. `redirect_pc_i[1:0]` is ignored (treated as 00).
- **States:**
  - FETCH: `imem_req_o = !redirect_i`.
    - If redirect_i: pc_q<=redirect target; stay FETCH.
    - Else: pc_q<=pc_q+4 (mod 2^32, wraps FFFFFFFC->0); go WAIT.
  - WAIT: `imem_req_o=0`; wait for `imem_rsp_valid_i`.
    - Response with drop_q=1: discard it, clear drop_q, go FETCH.
    - Response with !stall_i: load IF/ID (instruction_r=data, pc_r=address of that request, valid_r=1); go FETCH.
    - Response with stall_i: store data+PC in hold buffer; go HOLD.
  - HOLD: `imem_req_o=0`.
    - When !stall_i: load IF/ID from hold buffer, valid_r=1; go FETCH.
- **Latency:** back-to-back fetch uses 2 cycles per instruction with 1-cycle memory. Request at cycle N, response at N+1, IF/ID updated at edge ending N+1.
- **IF/ID retention:** while stall_i=1 and no redirect, instruction_r/pc_r/valid_r hold their values.
- **IF/ID on no-load edges:** with !stall_i and nothing to load, valid_r<=0 and instruction_r<=NOP_INSTR (bubble).
- **Redirect** (priority over stall_i and over a same-cycle response):
  - IF/ID <= NOP_INSTR, valid_r=0.
  - pc_q <= target; hold buffer invalidated.
  - In WAIT with the response not yet arrived: set drop_q, stay WAIT; the next response is discarded, then FETCH issues the target.
  - In WAIT with the response arriving the same cycle: discard it, go FETCH.
  - In HOLD: discard the buffer, go FETCH.
  - The request to the target is issued the cycle after redirect is sampled (FETCH issues `imem_req_o` only when redirect_i=0).
- **Outstanding requests:** never more than one; a new request is issued only in FETCH.
- **Spurious responses:** `imem_rsp_valid_i` outside WAIT is ignored.

Test Plan:
- **Reset then sequential fetch:** RESET_PC=0; memory returns 32'h00A00093@0, 32'hFFB08113@4, 1-cycle latency -> `imem_addr_o` 0 then 4. IF/ID shows (00A00093, pc 0, valid 1), then (FFB08113, pc 4). valid_r=0 and instruction_r=00000013 during reset.
- **Stall during response:** stall_i=1 on the cycle 32'h07F00193@8 returns -> state HOLD, IF/ID keeps the previous entry. After stall_i falls: IF/ID=(07F00193, pc 8), next request addr 0xC.
- **Redirect while waiting:** redirect_i=1, redirect_pc_i=0x40 while a response for 0x10 is pending -> the 0x10 response is dropped (never in IF/ID), valid_r=0 bubble. Next `imem_addr_o`=0x40; IF/ID later shows pc 0x40.
- **Redirect in HOLD with stall:** stall_i=1 with the buffer holding 32'h00D60463, redirect to 0x10 -> buffer discarded, valid_r=0, fetch of 0x10 issued the following cycle.
- **Misaligned redirect and PC wrap:** redirect_pc_i=0x0000_0046 -> `imem_addr_o`=0x44. Sequential fetch from 0xFFFFFFFC -> next addr 0x00000000.
- **Reset mid-operation:** rst asserted in WAIT with a pending response -> next cycle FETCH, `imem_addr_o`=RESET_PC, valid_r=0; the late response is ignored.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory port of the fetch stage: one request at a time, response
// returned one or more cycles later.
interface if_stage_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_rsp_valid_i;
   logic [31:0] imem_rsp_data_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_rsp_valid_i,
      input  imem_rsp_data_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_rsp_valid_i,
      output imem_rsp_data_i
   );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem requests, a one-entry
// hold buffer for responses that land during a decode stall, and the IF/ID register.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [31:0]       redirect_pc_i,
   if_stage_if.master        imem,
   output logic [31:0]       instruction_r,
   output logic [31:0]       pc_r,
   output logic              valid_r
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_stateNext;
   logic [31:0] r_pc;
   logic [31:0] w_pcNext;
   logic [31:0] r_reqPc;
   logic [31:0] w_reqPcNext;
   logic        r_drop;
   logic        w_dropNext;
   logic        r_holdValid;
   logic        w_holdValidNext;
   logic [31:0] r_holdData;
   logic [31:0] r_holdPc;
   logic        w_holdWrite;
   logic        w_load;
   logic [31:0] w_loadData;
   logic [31:0] w_loadPc;
   logic        w_bubble;

   assign imem.imem_req_o  = (r_state == FETCH) && !redirect_i;
   assign imem.imem_addr_o = r_pc & ~32'h3;

   // Redirect wins over stall and over a response arriving in the same cycle.
   always_comb begin
      w_stateNext     = r_state;
      w_pcNext        = r_pc;
      w_reqPcNext     = r_reqPc;
      w_dropNext      = r_drop;
      w_holdValidNext = r_holdValid;
      w_holdWrite     = 1'b0;
      w_load          = 1'b0;
      w_loadData      = imem.imem_rsp_data_i;
      w_loadPc        = r_reqPc;
      w_bubble        = !stall_i;

      if (redirect_i) begin
         w_pcNext        = redirect_pc_i & ~32'h3;
         w_holdValidNext = 1'b0;
         w_bubble        = 1'b1;
         case (r_state)
            FETCH: w_stateNext = FETCH;
            WAIT: begin
               if (imem.imem_rsp_valid_i) begin
                  w_dropNext  = 1'b0;
                  w_stateNext = FETCH;
               end else begin
                  w_dropNext  = 1'b1;
                  w_stateNext = WAIT;
               end
            end
            default: w_stateNext = FETCH;
         endcase
      end else begin
         case (r_state)
            FETCH: begin
               w_pcNext    = r_pc + 32'd4;
               w_reqPcNext = r_pc & ~32'h3;
               w_stateNext = WAIT;
            end
            WAIT: begin
               if (imem.imem_rsp_valid_i) begin
                  if (r_drop) begin
                     w_dropNext  = 1'b0;
                     w_stateNext = FETCH;
                  end else if (!stall_i) begin
                     w_load      = 1'b1;
                     w_stateNext = FETCH;
                  end else begin
                     w_holdWrite     = 1'b1;
                     w_holdValidNext = 1'b1;
                     w_stateNext     = HOLD;
                  end
               end
            end
            default: begin
               if (!stall_i) begin
                  w_load          = r_holdValid;
                  w_loadData      = r_holdData;
                  w_loadPc        = r_holdPc;
                  w_holdValidNext = 1'b0;
                  w_stateNext     = FETCH;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= FETCH;
         r_pc        <= RESET_PC & ~32'h3;
         r_reqPc     <= RESET_PC & ~32'h3;
         r_drop      <= 1'b0;
         r_holdValid <= 1'b0;
      end else begin
         r_state     <= w_stateNext;
         r_pc        <= w_pcNext;
         r_reqPc     <= w_reqPcNext;
         r_drop      <= w_dropNext;
         r_holdValid <= w_holdValidNext;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_holdData <= NOP_INSTR;
         r_holdPc   <= 32'h0;
      end else if (w_holdWrite) begin
         r_holdData <= imem.imem_rsp_data_i;
         r_holdPc   <= r_reqPc;
      end
   end

   // IF/ID holds on stall; otherwise it takes a new entry or a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         instruction_r <= NOP_INSTR;
         pc_r          <= 32'h0;
         valid_r       <= 1'b0;
      end else if (w_load) begin
         instruction_r <= w_loadData;
         pc_r          <= w_loadPc;
         valid_r       <= 1'b1;
      end else if (w_bubble) begin
         instruction_r <= NOP_INSTR;
         valid_r       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: the bench plays instruction memory by hand and
// checks PC/request outputs and the IF/ID register after each clock edge.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'h0;
   logic [31:0] instruction_r;
   logic [31:0] pc_r;
   logic        valid_r;
   int          nChecks = 0;
   int          nFails = 0;

   if_stage_if imem();

   if_stage #(
      .RESET_PC (32'h0000_0000),
      .NOP_INSTR(32'h0000_0013)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall_i),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .imem         (imem),
      .instruction_r(instruction_r),
      .pc_r         (pc_r),
      .valid_r      (valid_r)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic respond(input logic [31:0] data);
      imem.imem_rsp_valid_i = 1'b1;
      imem.imem_rsp_data_i  = data;
   endtask

   task automatic noRsp();
      imem.imem_rsp_valid_i = 1'b0;
      imem.imem_rsp_data_i  = 32'h0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      nChecks++; if ({valid_r, instruction_r} !== {1'b0, 32'h13}) begin nFails++; $display("[TB] FAIL reset_ifid: got %h expected %h", {valid_r, instruction_r}, {1'b0, 32'h13}); end
      nChecks++; if (pc_r !== 32'h0) begin nFails++; $display("[TB] FAIL reset_pc_r: got %h expected %h", pc_r, 32'h0); end
      nChecks++; if ({imem.imem_req_o, imem.imem_addr_o} !== {1'b1, 32'h0}) begin nFails++; $display("[TB] FAIL reset_req: got %h expected %h", {imem.imem_req_o, imem.imem_addr_o}, {1'b1, 32'h0}); end
      rst = 1'b0;
   endtask

   task automatic test_sequential();
      tick();
      nChecks++; if (imem.imem_req_o !== 1'b0) begin nFails++; $display("[TB] FAIL seq_wait_req: got %b expected 0", imem.imem_req_o); end
      respond(32'h00A00093);
      tick();
      noRsp();
      nChecks++; if ({valid_r, pc_r, instruction_r} !== {1'b1, 32'h0, 32'h00A00093}) begin nFails++; $display("[TB] FAIL seq_ifid0: got %h expected %h", {valid_r, pc_r, instruction_r}, {1'b1, 32'h0, 32'h00A00093}); end
      nChecks++; if ({imem.imem_req_o, imem.imem_addr_o} !== {1'b1, 32'h4}) begin nFails++; $display("[TB] FAIL seq_addr4: got %h expected %h", {imem.imem_req_o, imem.imem_addr_o}, {1'b1, 32'h4}); end
      tick();
      nChecks++; if ({valid_r, instruction_r} !== {1'b0, 32'h13}) begin nFails++; $display("[TB] FAIL seq_bubble: got %h expected %h", {valid_r, instruction_r}, {1'b0, 32'h13}); end
      respond(32'hFFB08113);
      tick();
      noRsp();
      nChecks++; if ({valid_r, pc_r, instruction_r} !== {1'b1, 32'h4, 32'hFFB08113}) begin nFails++; $display("[TB] FAIL seq_ifid4: got %h expected %h", {valid_r, pc_r, instruction_r}, {1'b1, 32'h4, 32'hFFB08113}); end
      nChecks++; if (imem.imem_addr_o !== 32'h8) begin nFails++; $display("[TB] FAIL seq_addr8: got %h expected %h", imem.imem_addr_o, 32'h8); end
   endtask

   task automatic test_stall();
      stall_i = 1'b1;
      tick();
      nChecks++; if ({valid_r, pc_r, instruction_r} !== {1'b1, 32'h4, 32'hFFB08113}) begin nFails++; $display("[TB] FAIL stall_retain: got %h expected %h", {valid_r, pc_r, instruction_r}, {1'b1, 32'h4, 32'hFFB08113}); end
      respond(32'h07F00193);
      tick();
      noRsp();
      nChecks++; if ({valid_r, pc_r, instruction_r} !== {1'b1, 32'h4, 32'hFFB08113}) begin nFails++; $display("[TB] FAIL stall_hold_ifid: got %h expected %h", {valid_r, pc_r, instruction_r}, {1'b1, 32'h4, 32'hFFB08113}); end
      nChecks++; if (imem.imem_req_o !== 1'b0) begin nFails++; $display("[TB] FAIL stall_hold_req: got %b expected 0", imem.imem_req_o); end
      respond(32'hDEADBEEF);
      tick();
      noRsp();
      nChecks++; if ({imem.imem_req_o, valid_r, instruction_r} !== {1'b0, 1'b1, 32'hFFB08113}) begin nFails++; $display("[TB] FAIL stall_spurious: got %h expected %h", {imem.imem_req_o, valid_r, instruction_r}, {1'b0, 1'b1, 32'hFFB08113}); end
      stall_i = 1'b0;
      tick();
      nChecks++; if ({valid_r, pc_r, instruction_r} !== {1'b1, 32'h8, 32'h07F00193}) begin nFails++; $display("[TB] FAIL stall_release: got %h expected %h", {valid_r, pc_r, instruction_r}, {1'b1, 32'h8, 32'h07F00193}); end
      nChecks++; if ({imem.imem_req_o, imem.imem_addr_o} !== {1'b1, 32'hC}) begin nFails++; $display("[TB] FAIL stall_next_addr: got %h expected %h", {imem.imem_req_o, imem.imem_addr_o}, {1'b1, 32'hC}); end
   endtask

   task automatic test_redirect_wait();
      tick();
      respond(32'h00000113);
      tick();
      noRsp();
      nChecks++; if ({valid_r, pc_r, imem.imem_addr_o} !== {1'b1, 32'hC, 32'h10}) begin nFails++; $display("[TB] FAIL rw_setup: got %h expected %h", {valid_r, pc_r, imem.imem_addr_o}, {1'b1, 32'hC, 32'h10}); end
      tick();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h40;
      tick();
      redirect_i = 1'b0;
      #1;
      nChecks++; if ({imem.imem_req_o, valid_r, instruction_r} !== {1'b0, 1'b0, 32'h13}) begin nFails++; $display("[TB] FAIL rw_bubble: got %h expected %h", {imem.imem_req_o, valid_r, instruction_r}, {1'b0, 1'b0, 32'h13}); end
      respond(32'hCAFE0093);
      tick();
      noRsp();
      nChecks++; if ({valid_r, instruction_r} !== {1'b0, 32'h13}) begin nFails++; $display("[TB] FAIL rw_dropped: got %h expected %h", {valid_r, instruction_r}, {1'b0, 32'h13}); end
      nChecks++; if ({imem.imem_req_o, imem.imem_addr_o} !== {1'b1, 32'h40}) begin nFails++; $display("[TB] FAIL rw_target_addr: got %h expected %h", {imem.imem_req_o, imem.imem_addr_o}, {1'b1, 32'h40}); end
      tick();
      respond(32'h00100093);
      tick();
      noRsp();
      nChecks++; if ({valid_r, pc_r, instruction_r} !== {1'b1, 32'h40, 32'h00100093}) begin nFails++; $display("[TB] FAIL rw_target_ifid: got %h expected %h", {valid_r, pc_r, instruction_r}, {1'b1, 32'h40, 32'h00100093}); end
   endtask

   task automatic test_redirect_hold();
      stall_i = 1'b1;
      tick();
      respond(32'h00D60463);
      tick();
      noRsp();
      nChecks++; if ({imem.imem_req_o, valid_r, pc_r} !== {1'b0, 1'b1, 32'h40}) begin nFails++; $display("[TB] FAIL rh_in_hold: got %h expected %h", {imem.imem_req_o, valid_r, pc_r}, {1'b0, 1'b1, 32'h40}); end
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h10;
      tick();
      redirect_i = 1'b0;
      #1;
      nChecks++; if ({valid_r, instruction_r} !== {1'b0, 32'h13}) begin nFails++; $display("[TB] FAIL rh_bubble: got %h expected %h", {valid_r, instruction_r}, {1'b0, 32'h13}); end
      nChecks++; if ({imem.imem_req_o, imem.imem_addr_o} !== {1'b1, 32'h10}) begin nFails++; $display("[TB] FAIL rh_target_addr: got %h expected %h", {imem.imem_req_o, imem.imem_addr_o}, {1'b1, 32'h10}); end
      stall_i = 1'b0;
      tick();
      nChecks++; if (valid_r !== 1'b0) begin nFails++; $display("[TB] FAIL rh_no_leak: got %b expected 0", valid_r); end
      respond(32'h00000213);
      tick();
      noRsp();
      nChecks++; if ({valid_r, pc_r, instruction_r} !== {1'b1, 32'h10, 32'h00000213}) begin nFails++; $display("[TB] FAIL rh_target_ifid: got %h expected %h", {valid_r, pc_r, instruction_r}, {1'b1, 32'h10, 32'h00000213}); end
   endtask

   task automatic test_redirect_same_cycle();
      tick();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h80;
      respond(32'h11111111);
      tick();
      redirect_i = 1'b0;
      noRsp();
      #1;
      nChecks++; if ({valid_r, imem.imem_req_o, imem.imem_addr_o} !== {1'b0, 1'b1, 32'h80}) begin nFails++; $display("[TB] FAIL rs_fetch_target: got %h expected %h", {valid_r, imem.imem_req_o, imem.imem_addr_o}, {1'b0, 1'b1, 32'h80}); end
      tick();
      respond(32'h00200113);
      tick();
      noRsp();
      nChecks++; if ({valid_r, pc_r, instruction_r} !== {1'b1, 32'h80, 32'h00200113}) begin nFails++; $display("[TB] FAIL rs_target_ifid: got %h expected %h", {valid_r, pc_r, instruction_r}, {1'b1, 32'h80, 32'h00200113}); end
   endtask

   task automatic test_misaligned_wrap();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h46;
      #1;
      nChecks++; if (imem.imem_req_o !== 1'b0) begin nFails++; $display("[TB] FAIL mw_req_masked: got %b expected 0", imem.imem_req_o); end
      tick();
      redirect_i = 1'b0;
      #1;
      nChecks++; if ({imem.imem_req_o, imem.imem_addr_o} !== {1'b1, 32'h44}) begin nFails++; $display("[TB] FAIL mw_aligned: got %h expected %h", {imem.imem_req_o, imem.imem_addr_o}, {1'b1, 32'h44}); end
      tick();
      respond(32'h00300193);
      tick();
      noRsp();
      nChecks++; if ({valid_r, pc_r, imem.imem_addr_o} !== {1'b1, 32'h44, 32'h48}) begin nFails++; $display("[TB] FAIL mw_after_align: got %h expected %h", {valid_r, pc_r, imem.imem_addr_o}, {1'b1, 32'h44, 32'h48}); end
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFC;
      tick();
      redirect_i = 1'b0;
      #1;
      nChecks++; if (imem.imem_addr_o !== 32'hFFFF_FFFC) begin nFails++; $display("[TB] FAIL mw_top_addr: got %h expected %h", imem.imem_addr_o, 32'hFFFF_FFFC); end
      tick();
      respond(32'h00400213);
      tick();
      noRsp();
      nChecks++; if ({valid_r, pc_r, instruction_r} !== {1'b1, 32'hFFFF_FFFC, 32'h00400213}) begin nFails++; $display("[TB] FAIL mw_top_ifid: got %h expected %h", {valid_r, pc_r, instruction_r}, {1'b1, 32'hFFFF_FFFC, 32'h00400213}); end
      nChecks++; if ({imem.imem_req_o, imem.imem_addr_o} !== {1'b1, 32'h0}) begin nFails++; $display("[TB] FAIL mw_wrap: got %h expected %h", {imem.imem_req_o, imem.imem_addr_o}, {1'b1, 32'h0}); end
   endtask

   task automatic test_reset_mid();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h20;
      tick();
      redirect_i = 1'b0;
      tick();
      nChecks++; if (imem.imem_req_o !== 1'b0) begin nFails++; $display("[TB] FAIL rm_in_wait: got %b expected 0", imem.imem_req_o); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      nChecks++; if ({imem.imem_req_o, imem.imem_addr_o, valid_r, instruction_r} !== {1'b1, 32'h0, 1'b0, 32'h13}) begin nFails++; $display("[TB] FAIL rm_after_reset: got %h expected %h", {imem.imem_req_o, imem.imem_addr_o, valid_r, instruction_r}, {1'b1, 32'h0, 1'b0, 32'h13}); end
      respond(32'hBADBAD13);
      tick();
      noRsp();
      nChecks++; if ({imem.imem_req_o, valid_r} !== {1'b0, 1'b0}) begin nFails++; $display("[TB] FAIL rm_late_ignored: got %h expected %h", {imem.imem_req_o, valid_r}, {1'b0, 1'b0}); end
      respond(32'h00A00093);
      tick();
      noRsp();
      nChecks++; if ({valid_r, pc_r, instruction_r} !== {1'b1, 32'h0, 32'h00A00093}) begin nFails++; $display("[TB] FAIL rm_refetch: got %h expected %h", {valid_r, pc_r, instruction_r}, {1'b1, 32'h0, 32'h00A00093}); end
   endtask

   initial begin
      imem.imem_rsp_valid_i = 1'b0;
      imem.imem_rsp_data_i  = 32'h0;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_wait();
      test_redirect_hold();
      test_redirect_same_cycle();
      test_misaligned_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
